fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the single write port of the clkA-side cross-clock FIFO among NREQ requesters in the clkA domain.
- Grants whole packets (multi-beat bursts) atomically, so beats from different requesters never interleave in the FIFO.
- Never presents a write while the FIFO reports full.
- Sits between clkA-domain producers and the FIFO's wrEnable/inputData/full signals.

Parameters:
- BITS, 8, data width; matches the FIFO word width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, owner-id width, equal to ceil(log2(NREQ)).
- MAX_BURST, 4, maximum beats per packet before forced release (1..15).
- TIMEOUT, 15, idle-owner cycles before forced release; used only with ARB_TIMEOUT_EN.

Ports:
- clkA  in  1  write-domain clock.
- rstA  in  1  asynchronous reset, active-low (already decided).
- req  in  NREQ  per-requester beat valid.
- reqLast  in  NREQ  per-requester last beat of packet; qualified by req.
- reqData  in  NREQ*BITS  requester i data at bits [i*BITS +: BITS].
- fifoFull  in  1  FIFO full flag, clkA domain.
- clrErr  in  1  synchronous clear of burstErr.
- grant  out  NREQ  one-hot beat accept; at most one bit set.
- fifoWrEnable  out  1  FIFO write strobe.
- fifoData  out  BITS  FIFO write data.
- ownerId  out  IDW  index of current or last owner.
- locked  out  1  high while a packet is in progress.
- burstErr  out  1  sticky error flag.

Behaviour:
- States: IDLE (no owner) and LOCKED (owner mid-packet). State, ownerId, rrPtr, beatCnt and burstErr are registered on posedge clkA.
- Reset (rstA low): state = IDLE, ownerId = 0, rrPtr = NREQ-1, beatCnt = 0, burstErr = 0, locked = 0. grant and fifoWrEnable are forced to 0. fifoData = 0.
- grant is combinational, with zero latency (same-cycle accept):
  - fifoFull = 1 -> grant = 0 in every state.
  - IDLE -> grant the first requester with req high, searching from rrPtr+1 mod NREQ upward with wrap.
  - LOCKED -> grant[ownerId] = req[ownerId]; all other grant bits are 0.
- fifoWrEnable = |grant. fifoData = reqData slice of the granted index; 0 when no grant.
- A beat is accepted when grant[i] is high. The requester must hold req/reqData/reqLast stable until it is granted.
- Beat end condition: an accepted beat ends the packet if reqLast = 1 or beatCnt+1 == MAX_BURST.
- Transitions:
  - IDLE, accepted beat that ends the packet -> stay IDLE; rrPtr <= i; ownerId <= i.
  - IDLE, accepted beat that does not end the packet -> LOCKED; ownerId <= i; beatCnt <= 1.
  - LOCKED, accepted beat that ends the packet -> IDLE; rrPtr <= ownerId; beatCnt <= 0.
  - LOCKED, accepted beat that does not end the packet -> beatCnt + 1.
  - No accepted beat (full, or owner req low) -> hold all state. A gap in the owner's req is a legal bubble.
- Forced release: beatCnt reaching MAX_BURST without reqLast sets burstErr = 1. The next beat from that requester starts a new packet.
- burstErr is sticky and cleared by clrErr = 1. If set and clear occur in the same cycle, set wins.
- beatCnt is 4 bits and never exceeds MAX_BURST.
- rrPtr advances only at end of packet, so fairness is per packet, not per beat.
- Reset asserted mid-packet aborts the packet; no further writes occur. The FIFO keeps any beats already written.
- locked = (state == LOCKED).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit idle counter increments each LOCKED cycle in which req[ownerId] = 0 and fifoFull = 0.
  - The counter resets to 0 on any accepted beat and on leaving LOCKED.
  - When it reaches TIMEOUT: state -> IDLE, rrPtr <= ownerId, burstErr = 1.
- Undefined: no counter; LOCKED waits indefinitely for the owner.

Test Plan:
- Reset: hold rstA = 0 with req = 4'b1111 -> grant = 0, fifoWrEnable = 0, locked = 0, burstErr = 0.
- Round-robin: after reset, req = 4'b1111 and reqLast = 4'b1111 held for 5 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001. fifoData equals the matching reqData slice each cycle.
- Packet atomicity: requester 1 sends 3 beats (A1, A2, A3, last on A3) while requester 2 is requesting -> FIFO receives A1, A2, A3, then requester 2's beat. locked is high for 2 cycles.
- Full stall: fifoFull = 1 for 3 cycles mid-packet (after beat 2 of 4) -> grant = 0 for those cycles. Beats 3 and 4 follow with no loss or duplication. beatCnt is held.
- MAX_BURST = 4 overrun: requester 0 sends 6 beats with reqLast never set -> release after beat 4, burstErr = 1. clrErr pulse -> burstErr = 0.
- ARB_TIMEOUT_EN, TIMEOUT = 15: owner drops req after beat 1 -> locked falls after 15 idle cycles, burstErr = 1, and the next requester is granted on the following cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic arbiter for the clkA write port of the CDC FIFO.
// Optional idle-owner timeout release: define ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
    parameter int BITS      = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clkA,
    input  logic                 rstA,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      reqLast,
    input  logic [NREQ*BITS-1:0] reqData,
    input  logic                 fifoFull,
    input  logic                 clrErr,
    output logic [NREQ-1:0]      grant,
    output logic                 fifoWrEnable,
    output logic [BITS-1:0]      fifoData,
    output logic [IDW-1:0]       ownerId,
    output logic                 locked,
    output logic                 burstErr
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    if (NREQ < 2 || NREQ > 8 || IDW < $clog2(NREQ) ||
        MAX_BURST < 1 || MAX_BURST > 15 ||
        TIMEOUT < 1 || TIMEOUT > 15) begin : g_param_chk
        $error("fifo_wr_arbiter: parameter out of range");
    end

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] ptr_nx;
    logic [IDW-1:0] owner_nx;
    logic [3:0]     beat_cnt;
    logic [3:0]     cnt_nx;
    logic [3:0]     beat_inc;
    logic [IDW-1:0] pick;
    logic           pick_vld;
    logic [IDW-1:0] sel;
    logic           accept;
    logic           ends;
    logic           overrun;
    logic           err_set;
    logic           err_nx;
`ifdef ARB_TIMEOUT_EN
    logic [3:0]     idle_cnt;
    logic [3:0]     idle_nx;
`endif

    // Rotating priority search: first requester after rr_ptr, with wrap.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                pick     = IDW'((int'(rr_ptr) + k) % NREQ);
                pick_vld = 1'b1;
            end
        end
    end

    // Same-cycle grant; nothing is accepted in reset or while the FIFO is full.
    always_comb begin
        grant = '0;
        sel   = (state == IDLE) ? pick : ownerId;
        if (rstA && !fifoFull) begin
            if (state == IDLE) begin
                if (pick_vld) begin
                    grant[pick] = 1'b1;
                end
            end else if (req[ownerId]) begin
                grant[ownerId] = 1'b1;
            end
        end
    end

    assign accept       = |grant;
    assign fifoWrEnable = accept;
    assign fifoData     = accept ? reqData[int'(sel)*BITS +: BITS] : '0;
    assign beat_inc     = beat_cnt + 4'd1;
    assign overrun      = ~reqLast[sel] & (beat_inc == 4'(MAX_BURST));
    assign ends         = reqLast[sel] | overrun;
    assign locked       = (state == LOCKED);
    assign err_nx       = err_set | (burstErr & ~clrErr);

    // Packet tracking: ownership, beat count and fairness pointer.
    always_comb begin
        state_nx = state;
        owner_nx = ownerId;
        ptr_nx   = rr_ptr;
        cnt_nx   = beat_cnt;
        err_set  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        idle_nx  = idle_cnt;
`endif
        if (accept) begin
            owner_nx = sel;
            err_set  = overrun;
`ifdef ARB_TIMEOUT_EN
            idle_nx  = '0;
`endif
            if (ends) begin
                state_nx = IDLE;
                ptr_nx   = sel;
                cnt_nx   = '0;
            end else begin
                state_nx = LOCKED;
                cnt_nx   = beat_inc;
            end
        end
`ifdef ARB_TIMEOUT_EN
        else if (state == LOCKED && !req[ownerId] && !fifoFull) begin
            if (idle_cnt == 4'(TIMEOUT - 1)) begin
                state_nx = IDLE;
                ptr_nx   = ownerId;
                cnt_nx   = '0;
                idle_nx  = '0;
                err_set  = 1'b1;
            end else begin
                idle_nx = idle_cnt + 4'd1;
            end
        end
`endif
    end

    // State registers; reset aborts any packet in flight.
    always_ff @(posedge clkA or negedge rstA) begin
        if (!rstA) begin
            state    <= IDLE;
            ownerId  <= '0;
            rr_ptr   <= IDW'(NREQ - 1);
            beat_cnt <= '0;
            burstErr <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            state    <= state_nx;
            ownerId  <= owner_nx;
            rr_ptr   <= ptr_nx;
            beat_cnt <= cnt_nx;
            burstErr <= err_nx;
`ifdef ARB_TIMEOUT_EN
            idle_cnt <= idle_nx;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a packet-level reference model.
// Honours ARB_TIMEOUT_EN the same way the design does.
module tb_fifo_wr_arbiter;

    localparam int BITS = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int MAXB = 4;
    localparam int TOUT = 15;

    logic                 clkA = 1'b0;
    logic                 rstA;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      reqLast;
    logic [NREQ*BITS-1:0] reqData;
    logic                 fifoFull;
    logic                 clrErr;
    logic [NREQ-1:0]      grant;
    logic                 fifoWrEnable;
    logic [BITS-1:0]      fifoData;
    logic [IDW-1:0]       ownerId;
    logic                 locked;
    logic                 burstErr;

    int npass = 0;
    int ntot  = 0;

    fifo_wr_arbiter #(
        .BITS(BITS), .NREQ(NREQ), .IDW(IDW),
        .MAX_BURST(MAXB), .TIMEOUT(TOUT)
    ) dut (
        .clkA(clkA), .rstA(rstA), .req(req), .reqLast(reqLast),
        .reqData(reqData), .fifoFull(fifoFull), .clrErr(clrErr),
        .grant(grant), .fifoWrEnable(fifoWrEnable), .fifoData(fifoData),
        .ownerId(ownerId), .locked(locked), .burstErr(burstErr)
    );

    always #5 clkA = ~clkA;

    task automatic chk(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Model: owner -1 means nobody holds the port.
    int m_own = -1, m_cnt = 0, m_ptr = NREQ - 1, m_last = 0, m_idle = 0;
    bit m_err = 0;
    int n_own = -1, n_cnt = 0, n_ptr = NREQ - 1, n_last = 0, n_idle = 0;
    bit n_err = 0;

    always @(posedge clkA) begin
        m_own = n_own; m_cnt = n_cnt; m_ptr = n_ptr;
        m_last = n_last; m_err = n_err; m_idle = n_idle;
    end

    always @(negedge clkA) begin
        int gi;
        int eg;
        int ed;
        bit set;
        if (!rstA) begin
            m_own = -1; m_cnt = 0; m_ptr = NREQ - 1;
            m_last = 0; m_err = 0; m_idle = 0;
        end
        gi = -1;
        if (rstA && !fifoFull) begin
            if (m_own < 0) begin
                for (int k = 1; k <= NREQ && gi < 0; k++)
                    if (req[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
            end else if (req[m_own]) begin
                gi = m_own;
            end
        end
        eg = (gi >= 0) ? (1 << gi) : 0;
        ed = (gi >= 0) ? int'(reqData[gi*BITS +: BITS]) : 0;
        chk("m_grant", int'(grant), eg);
        chk("m_wren", int'(fifoWrEnable), int'(gi >= 0));
        chk("m_data", int'(fifoData), ed);
        chk("m_owner", int'(ownerId), m_last);
        chk("m_locked", int'(locked), int'(m_own >= 0));
        chk("m_err", int'(burstErr), int'(m_err));
        n_own = m_own; n_cnt = m_cnt; n_ptr = m_ptr;
        n_last = m_last; n_idle = m_idle; set = 0;
        if (gi >= 0) begin
            n_last = gi;
            n_idle = 0;
            if (reqLast[gi] || m_cnt + 1 == MAXB) begin
                set = !reqLast[gi];
                n_own = -1; n_ptr = gi; n_cnt = 0;
            end else begin
                n_own = gi; n_cnt = m_cnt + 1;
            end
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_own >= 0 && !req[m_own] && !fifoFull) begin
            n_idle = m_idle + 1;
            if (n_idle == TOUT) begin
                n_own = -1; n_ptr = m_own; n_cnt = 0; n_idle = 0; set = 1;
            end
        end
`endif
        n_err = set ? 1'b1 : (clrErr ? 1'b0 : m_err);
        if (!rstA) begin
            n_own = -1; n_cnt = 0; n_ptr = NREQ - 1;
            n_last = 0; n_err = 0; n_idle = 0;
        end
    end

    task automatic tick();
        @(posedge clkA);
        #1;
    endtask

    task automatic setd(input int i, input logic [7:0] v);
        reqData[i*BITS +: BITS] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_g [5];
        logic [7:0] rr_d [5];
        rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        rstA = 0; req = '1; reqLast = '0; reqData = 32'h44332211;
        fifoFull = 0; clrErr = 0;
        tick(); tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_wren", int'(fifoWrEnable), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(burstErr), 0);
        rstA = 1; req = '0;
        tick();

        req = 4'b1111; reqLast = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", int'(grant), int'(rr_g[k]));
            chk("rr_data", int'(fifoData), int'(rr_d[k]));
            tick();
        end
        req = '0; reqLast = '0;
        tick();

        req = 4'b0110; setd(1, 8'hA1); setd(2, 8'hB1);
        #1; chk("pk_g1", int'(grant), 2); chk("pk_d1", int'(fifoData), 'hA1);
        chk("pk_l1", int'(locked), 0);
        tick(); setd(1, 8'hA2);
        #1; chk("pk_g2", int'(grant), 2); chk("pk_d2", int'(fifoData), 'hA2);
        chk("pk_l2", int'(locked), 1);
        tick(); setd(1, 8'hA3); reqLast = 4'b0010;
        #1; chk("pk_g3", int'(grant), 2); chk("pk_d3", int'(fifoData), 'hA3);
        chk("pk_l3", int'(locked), 1);
        tick(); req = 4'b0100; reqLast = 4'b0100;
        #1; chk("pk_g4", int'(grant), 4); chk("pk_d4", int'(fifoData), 'hB1);
        chk("pk_l4", int'(locked), 0);
        tick(); req = '0; reqLast = '0;
        tick();

        req = 4'b1000; setd(3, 8'hD1);
        #1; chk("fs_g1", int'(grant), 8);
        tick(); setd(3, 8'hD2);
        #1; chk("fs_g2", int'(grant), 8);
        tick(); fifoFull = 1; setd(3, 8'hD3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fs_stall_g", int'(grant), 0);
            chk("fs_stall_l", int'(locked), 1);
            tick();
        end
        fifoFull = 0;
        #1; chk("fs_g3", int'(grant), 8); chk("fs_d3", int'(fifoData), 'hD3);
        tick(); setd(3, 8'hD4); reqLast = 4'b1000;
        #1; chk("fs_g4", int'(grant), 8); chk("fs_d4", int'(fifoData), 'hD4);
        tick(); req = '0; reqLast = '0;
        #1; chk("fs_end_l", int'(locked), 0);
        tick();

        req = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            setd(0, 8'h60 + 8'(k));
            clrErr = (k == 7);
            #1; chk("ov_grant", int'(grant), 1);
            tick();
            if (k == 3) begin
                chk("ov_err", int'(burstErr), 1);
                chk("ov_locked", int'(locked), 0);
            end
        end
        clrErr = 0; req = '0;
        #1; chk("ov_setwins", int'(burstErr), 1);
        clrErr = 1;
        tick(); clrErr = 0;
        #1; chk("ov_clr", int'(burstErr), 0);
        tick();

        req = 4'b0110; setd(1, 8'h71); setd(2, 8'h72);
        #1; chk("to_g1", int'(grant), 2);
        tick(); req = 4'b0100;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < TOUT; k++) begin
            #1; chk("to_wait_l", int'(locked), 1);
            tick();
        end
        #1;
        chk("to_rel_l", int'(locked), 0);
        chk("to_rel_err", int'(burstErr), 1);
        chk("to_next_g", int'(grant), 4);
        tick();
`else
        for (int k = 0; k < 20; k++) begin
            #1; chk("hold_l", int'(locked), 1); chk("hold_g", int'(grant), 0);
            tick();
        end
        req = 4'b0110; reqLast = 4'b0010;
        #1; chk("hold_g2", int'(grant), 2);
        tick(); req = 4'b0100; reqLast = 4'b0100;
        #1; chk("hold_next", int'(grant), 4);
        tick();
`endif
        req = 4'b0001; reqLast = '0;
        tick();
        rstA = 0;
        #1;
        chk("rst_mid_g", int'(grant), 0);
        chk("rst_mid_l", int'(locked), 0);
        chk("rst_mid_we", int'(fifoWrEnable), 0);
        tick();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
